cd_rx_des: RTL and testbench
============================

CD_RX_DES -- requirements
Module: cd_rx_des

Interface
REQ-001 The block SHALL have a single clock domain and an asynchronous, active-low reset, with the ports listed in REQ-002 to REQ-013.
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 rx  input  1  raw bus line, asynchronous to clk, idle high.
REQ-005 period_ls  input  16  clocks per bit minus 1, low-speed rate; min 3; static during a frame.
REQ-006 period_hs  input  16  clocks per bit minus 1, high-speed rate; min 3; static during a frame.
REQ-007 idle_wait_len  input  8  low-speed bit times of continuous high rx that declare bus idle; 0 treated as 1.
REQ-008 force_wait_idle  input  1  one-cycle pulse; abandons the current frame and re-qualifies idle.
REQ-009 bus_idle  output  1  high while the bus is idle.
REQ-010 data  output  8  last received byte, held until the next byte.
REQ-011 data_clk  output  1  one-cycle strobe, data valid.
REQ-012 crc_data  output  16  running CRC over all bytes of the current frame up to and including data.
REQ-013 frame_err  output  1  one-cycle pulse on false start or bad stop bit.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs; a falling edge is rxs 1->0 between consecutive cycles.
REQ-015 States SHALL be WAIT_IDLE, IDLE, START, DATA, STOP.
REQ-016 WAIT_IDLE: bus_idle=0; clock counter and bit-time counter run at period_ls while rxs=1; any rxs=0 clears both; after idle_wait_len full bit times -> IDLE.
REQ-017 IDLE: bus_idle=1; crc_data held at 0xFFFF; byte index cleared; falling edge -> START, bus_idle=0 in the same cycle.
REQ-018 Bit period SHALL be period_ls for byte index 0 and period_hs for every later byte of the frame.
REQ-019 START: counter loads (period>>1); at expiry rxs=1 -> frame_err pulse, WAIT_IDLE; rxs=0 -> DATA.
REQ-020 DATA: sample rxs every period+1 clocks at mid-bit, 8 bits, LSB first into a shift register.
REQ-021 CRC SHALL be CRC-16/MODBUS (reflected poly 0xA001, init 0xFFFF, no final xor), updated one bit per data-bit sample, so crc_data includes the byte when data_clk asserts.
REQ-022 STOP: sample at mid-bit; rxs=1 -> data<=byte, data_clk=1 for one cycle, byte index+1 (saturating at 511), then the post-byte wait.
REQ-023 STOP with rxs=0 -> frame_err pulse, no data_clk, WAIT_IDLE with counters cleared.
REQ-024 Post-byte wait SHALL be WAIT_IDLE with the idle counters cleared, except that a falling edge there -> START (next byte, crc_data not reinitialized).
REQ-025 A falling edge in WAIT_IDLE before the first byte of a frame (byte index 0) SHALL only clear counters.
REQ-026 force_wait_idle SHALL, from any state, force WAIT_IDLE, bus_idle=0, counters cleared, byte index 0, crc_data=0xFFFF, suppressing any data_clk in that cycle; it has priority over all other events.
REQ-027 A falling edge coincident with idle-count expiry SHALL yield IDLE then START on the next cycle.

Reset
REQ-028 On reset_n=0: state WAIT_IDLE, bus_idle=0, data=0x00, data_clk=0, crc_data=0xFFFF, frame_err=0, counters 0, synchronizer flops 1.
REQ-029 After release, bus_idle SHALL rise only after idle_wait_len full low-speed bit times of rx high.

Verification
REQ-030 period_ls=7, idle_wait_len=10, rx high after reset -> bus_idle rises 80 clocks (+2 sync) after release.
REQ-031 Idle, send 0x01 at period_ls=7 -> data_clk once, data=0x01, crc_data=0x807E.
REQ-032 Send 0xA5 at period_ls=15, then 0x3C at period_hs=3 -> two data_clk, data 0xA5 then 0x3C, second byte decoded at hs timing.
REQ-033 Send a frame plus its CRC low then high byte -> crc_data=0x0000 at the last data_clk.
REQ-034 rx low for 2 clocks only, period_ls=7 -> frame_err pulse, no data_clk, bus_idle re-asserts after 10 idle bit times.
REQ-035 Stop bit forced low -> frame_err, no data_clk; force_wait_idle mid-byte -> bus_idle=0, crc_data=0xFFFF, no data_clk.

Source files
------------

// File: rtl/cd_rx_des.sv
// cd_rx_des: asynchronous serial byte receiver with bus-idle qualification and CRC-16/MODBUS.
//
// Frames are sequences of 8N1 bytes (start bit low, 8 data bits LSB first, stop bit high).
// The first byte of a frame runs at the low-speed bit period and later bytes at the
// high-speed period. The bus must be high for idle_wait_len low-speed bit times before
// a new frame is accepted.
//
// Ports:
//   clk             system clock, all state on the rising edge
//   reset_n         asynchronous active-low reset
//   rx              raw bus line, asynchronous to clk, idle high
//   period_ls       clocks per bit minus 1, low-speed (first byte of a frame)
//   period_hs       clocks per bit minus 1, high-speed (later bytes of a frame)
//   idle_wait_len   low-speed bit times of high rx that declare the bus idle (0 acts as 1)
//   force_wait_idle one-cycle pulse: abandon the frame and re-qualify idle
//   bus_idle        high while the bus is idle
//   data            last received byte, held until the next byte
//   data_clk        one-cycle strobe, data valid
//   crc_data        running CRC over the bytes of the current frame, including data
//   frame_err       one-cycle pulse on false start or bad stop bit
module cd_rx_des (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx,
  input  logic [15:0] period_ls,
  input  logic [15:0] period_hs,
  input  logic [7:0]  idle_wait_len,
  input  logic        force_wait_idle,
  output logic        bus_idle,
  output logic [7:0]  data,
  output logic        data_clk,
  output logic [15:0] crc_data,
  output logic        frame_err
);

  localparam logic [2:0] StWaitIdle = 3'd0;
  localparam logic [2:0] StIdle     = 3'd1;
  localparam logic [2:0] StStart    = 3'd2;
  localparam logic [2:0] StData     = 3'd3;
  localparam logic [2:0] StStop     = 3'd4;

  localparam logic [15:0] CrcInit = 16'hFFFF;
  localparam logic [15:0] CrcPoly = 16'hA001;

  // Synchronizer plus one history flop for edge detection.
  logic rx_meta_q, rxs_q, rxs_prev_q;

  logic [2:0]  state_q, state_d;
  // Up-counter within a bit time in StWaitIdle; down-counter to the sample point elsewhere.
  logic [15:0] cnt_q, cnt_d;
  // Idle bit times in StWaitIdle; data bit index in StData.
  logic [7:0]  bit_cnt_q, bit_cnt_d;
  logic [8:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  data_q, data_d;
  logic        data_clk_q, data_clk_d;
  logic        frame_err_q, frame_err_d;
  // Falling edge seen in the same cycle the idle count expired; start on the next cycle.
  logic        pend_q, pend_d;

  logic        fall;
  logic [15:0] period;
  logic [7:0]  idle_len;
  logic        idle_done;
  logic [15:0] crc_bit;

  assign fall     = rxs_prev_q & ~rxs_q;
  assign period   = (byte_idx_q == 9'd0) ? period_ls : period_hs;
  assign idle_len = (idle_wait_len == 8'd0) ? 8'd1 : idle_wait_len;
  // Last clock of the last required idle bit time. Only reachable with rxs high on the
  // previous cycle, so a low rxs here is necessarily a falling edge.
  assign idle_done = (cnt_q == period_ls) && (bit_cnt_q == idle_len - 8'd1);
  assign crc_bit  = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ rxs_q) ? CrcPoly : 16'h0000);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_idx_d  = byte_idx_q;
    shreg_d     = shreg_q;
    crc_d       = crc_q;
    data_d      = data_q;
    data_clk_d  = 1'b0;
    frame_err_d = 1'b0;
    pend_d      = 1'b0;

    if (force_wait_idle) begin
      state_d    = StWaitIdle;
      cnt_d      = 16'd0;
      bit_cnt_d  = 8'd0;
      byte_idx_d = 9'd0;
      crc_d      = CrcInit;
    end else begin
      case (state_q)
        StWaitIdle: begin
          if (idle_done) begin
            state_d   = StIdle;
            pend_d    = fall;
            cnt_d     = 16'd0;
            bit_cnt_d = 8'd0;
          end else if (fall && (byte_idx_q != 9'd0)) begin
            // Start bit of the next byte of the current frame.
            state_d   = StStart;
            cnt_d     = period >> 1;
            bit_cnt_d = 8'd0;
          end else if (!rxs_q) begin
            cnt_d     = 16'd0;
            bit_cnt_d = 8'd0;
          end else if (cnt_q == period_ls) begin
            cnt_d     = 16'd0;
            bit_cnt_d = bit_cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        StIdle: begin
          crc_d      = CrcInit;
          byte_idx_d = 9'd0;
          bit_cnt_d  = 8'd0;
          if (fall || pend_q) begin
            state_d = StStart;
            cnt_d   = period_ls >> 1;
          end
        end

        StStart: begin
          if (cnt_q == 16'd0) begin
            bit_cnt_d = 8'd0;
            if (rxs_q) begin
              frame_err_d = 1'b1;
              state_d     = StWaitIdle;
              byte_idx_d  = 9'd0;
            end else begin
              state_d = StData;
              cnt_d   = period;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end

        StData: begin
          if (cnt_q == 16'd0) begin
            shreg_d = {rxs_q, shreg_q[7:1]};
            crc_d   = crc_bit;
            cnt_d   = period;
            if (bit_cnt_q == 8'd7) begin
              state_d   = StStop;
              bit_cnt_d = 8'd0;
            end else begin
              bit_cnt_d = bit_cnt_q + 8'd1;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end

        StStop: begin
          if (cnt_q == 16'd0) begin
            state_d   = StWaitIdle;
            cnt_d     = 16'd0;
            bit_cnt_d = 8'd0;
            if (rxs_q) begin
              data_d     = shreg_q;
              data_clk_d = 1'b1;
              if (byte_idx_q != 9'd511) begin
                byte_idx_d = byte_idx_q + 9'd1;
              end
            end else begin
              // Frame is abandoned: a fresh idle qualification is needed before the next one.
              frame_err_d = 1'b1;
              byte_idx_d  = 9'd0;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end

        default: begin
          state_d   = StWaitIdle;
          cnt_d     = 16'd0;
          bit_cnt_d = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StWaitIdle;
      cnt_q       <= 16'd0;
      bit_cnt_q   <= 8'd0;
      byte_idx_q  <= 9'd0;
      shreg_q     <= 8'd0;
      crc_q       <= CrcInit;
      data_q      <= 8'd0;
      data_clk_q  <= 1'b0;
      frame_err_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shreg_q     <= shreg_d;
      crc_q       <= crc_d;
      data_q      <= data_d;
      data_clk_q  <= data_clk_d;
      frame_err_q <= frame_err_d;
      pend_q      <= pend_d;
    end
  end

  assign bus_idle  = (state_q == StIdle);
  assign data      = data_q;
  assign data_clk  = data_clk_q;
  assign crc_data  = crc_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_cd_rx_des.sv
// tb_cd_rx_des: directed + randomized bench for cd_rx_des with a byte-level reference model.
module tb_cd_rx_des;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        rx;
  logic [15:0] period_ls;
  logic [15:0] period_hs;
  logic [7:0]  idle_wait_len;
  logic        force_wait_idle;
  logic        bus_idle;
  logic [7:0]  data;
  logic        data_clk;
  logic [15:0] crc_data;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  byte unsigned got_data[$];
  logic [15:0]  got_crc[$];
  int           n_ferr = 0;

  always #5 clk = ~clk;

  cd_rx_des dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .rx              (rx),
    .period_ls       (period_ls),
    .period_hs       (period_hs),
    .idle_wait_len   (idle_wait_len),
    .force_wait_idle (force_wait_idle),
    .bus_idle        (bus_idle),
    .data            (data),
    .data_clk        (data_clk),
    .crc_data        (crc_data),
    .frame_err       (frame_err)
  );

  // Output monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (data_clk) begin
        got_data.push_back(data);
        got_crc.push_back(crc_data);
      end
      if (frame_err) n_ferr++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC-16/MODBUS over the first n bytes, byte-wise textbook form.
  function automatic logic [15:0] crc16(input byte unsigned b[$], input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      c = c ^ {8'h00, b[k]};
      for (int j = 0; j < 8; j++) begin
        c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
    end
    return c;
  endfunction

  // One 8N1 character, p+1 clocks per bit; optional force pulse at the start of bit force_bit
  // (0 = start bit, 1..8 data, 9 stop).
  task automatic send_byte(input logic [7:0] b, input int p, input logic stop_ok,
                           input int force_bit);
    for (int i = 0; i < 10; i++) begin
      logic v;
      v  = (i == 0) ? 1'b0 : ((i == 9) ? stop_ok : b[i-1]);
      rx = v;
      if (i == force_bit) begin
        force_wait_idle = 1'b1;
        @(negedge clk);
        force_wait_idle = 1'b0;
        check("force_bus_idle", {31'd0, bus_idle}, 32'd0);
        check("force_crc", {16'd0, crc_data}, 32'h0000FFFF);
        check("force_no_strobe", {31'd0, data_clk}, 32'd0);
        repeat (p) @(negedge clk);
      end else begin
        repeat (p + 1) @(negedge clk);
      end
    end
    rx = 1'b1;
  endtask

  task automatic send_frame(input byte unsigned b[$]);
    for (int k = 0; k < b.size(); k++) begin
      int p;
      p = (k == 0) ? int'(period_ls) : int'(period_hs);
      send_byte(b[k], p, 1'b1, -1);
      // Short inter-byte gap, well below the idle qualification time.
      repeat ($urandom_range(0, 2) * (p + 1)) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!bus_idle && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, bus_idle}, 32'd1);
  endtask

  task automatic check_frame(input string tag, input byte unsigned b[$]);
    check({tag, "_count"}, 32'(got_data.size()), 32'(b.size()));
    for (int k = 0; k < b.size() && k < got_data.size(); k++) begin
      check($sformatf("%s_data%0d", tag, k), {24'd0, got_data[k]}, {24'd0, b[k]});
      check($sformatf("%s_crc%0d", tag, k), {16'd0, got_crc[k]}, {16'd0, crc16(b, k + 1)});
    end
  endtask

  initial begin
    byte unsigned fr[$];
    logic [15:0]  c;

    rx              = 1'b1;
    force_wait_idle = 1'b0;
    period_ls       = 16'd7;
    period_hs       = 16'd3;
    idle_wait_len   = 8'd10;
    reset_n         = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_bus_idle", {31'd0, bus_idle}, 32'd0);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_data_clk", {31'd0, data_clk}, 32'd0);
    check("rst_crc", {16'd0, crc_data}, 32'h0000FFFF);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);

    // Idle qualification: 10 bit times of 8 clocks after release, with 2 clocks of slack.
    reset_n = 1'b1;
    repeat (79) @(posedge clk);
    #1;
    check("idle_not_early", {31'd0, bus_idle}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_80", {31'd0, bus_idle}, 32'd1);
    @(negedge clk);

    // Single byte 0x01 at the low-speed rate.
    got_data.delete(); got_crc.delete(); n_ferr = 0;
    fr = '{8'h01};
    send_frame(fr);
    repeat (4) @(negedge clk);
    check_frame("b01", fr);
    check("b01_crc_const", {16'd0, crc_data}, 32'h0000807E);
    check("b01_data_held", {24'd0, data}, 32'h01);
    check("b01_no_ferr", 32'(n_ferr), 32'd0);
    wait_idle("b01_idle", 400);

    // First byte at period 15, second at period 3.
    period_ls = 16'd15;
    got_data.delete(); got_crc.delete(); n_ferr = 0;
    fr = '{8'hA5, 8'h3C};
    send_frame(fr);
    repeat (4) @(negedge clk);
    check_frame("ls_hs", fr);
    check("ls_hs_no_ferr", 32'(n_ferr), 32'd0);
    wait_idle("ls_hs_idle", 600);
    period_ls = 16'd7;

    // Random frames carrying their own CRC: residue must be zero at the last strobe.
    for (int f = 0; f < 3; f++) begin
      int n;
      n = $urandom_range(2, 4);
      fr.delete();
      for (int k = 0; k < n; k++) fr.push_back(8'($urandom_range(0, 255)));
      c = crc16(fr, n);
      fr.push_back(c[7:0]);
      fr.push_back(c[15:8]);
      got_data.delete(); got_crc.delete(); n_ferr = 0;
      send_frame(fr);
      repeat (4) @(negedge clk);
      check_frame($sformatf("rnd%0d", f), fr);
      check($sformatf("rnd%0d_residue", f), {16'd0, crc_data}, 32'd0);
      wait_idle($sformatf("rnd%0d_idle", f), 400);
    end

    // False start: rx low for only 2 clocks.
    got_data.delete(); got_crc.delete(); n_ferr = 0;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("fstart_ferr", 32'(n_ferr), 32'd1);
    check("fstart_no_data", 32'(got_data.size()), 32'd0);
    check("fstart_not_idle", {31'd0, bus_idle}, 32'd0);
    wait_idle("fstart_idle", 200);

    // Stop bit held low.
    got_data.delete(); got_crc.delete(); n_ferr = 0;
    send_byte(8'($urandom_range(0, 255)), 7, 1'b0, -1);
    repeat (20) @(negedge clk);
    check("stop_ferr", 32'(n_ferr), 32'd1);
    check("stop_no_data", 32'(got_data.size()), 32'd0);
    wait_idle("stop_idle", 200);

    // force_wait_idle in the middle of a byte.
    got_data.delete(); got_crc.delete(); n_ferr = 0;
    send_byte(8'($urandom_range(0, 255)), 7, 1'b1, 4);
    repeat (20) @(negedge clk);
    check("force_no_data", 32'(got_data.size()), 32'd0);
    check("force_no_ferr", 32'(n_ferr), 32'd0);
    wait_idle("force_idle", 200);
    check("force_crc_idle", {16'd0, crc_data}, 32'h0000FFFF);

    // Receiver still works after the abandoned byte.
    got_data.delete(); got_crc.delete(); n_ferr = 0;
    fr = '{8'($urandom_range(0, 255))};
    send_frame(fr);
    repeat (4) @(negedge clk);
    check_frame("post_force", fr);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
